// File: rtl/rambus_wave_reader_pkg.sv
// Shared definitions for the rambus wave reader: bus FSM encoding, default
// sizing and the byte-lane helper used to unpack FIFO words into samples.
package rambus_wave_reader_pkg;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_REQ  = 1'b1
    } bus_state_t;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 255;
    localparam int WORD_W         = 32;

    // Little-endian byte lane: idx 0 selects bits 7:0.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] word,
                                             input logic [1:0]        idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rambus_word_fifo.sv
// Small synchronous word FIFO holding fetched RAM words until the sample
// engine has consumed all four bytes; flush empties it in one cycle.
module rambus_word_fifo
    import rambus_wave_reader_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = WORD_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rambus_wave_reader.sv
// Streams 8-bit samples out of a word-addressed RAM over a single-read bus
// master, prefetching words into a small FIFO and pacing output by period_i.
module rambus_wave_reader
    import rambus_wave_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        enable_i,
    input  logic [7:0]  start_word_i,
    input  logic [7:0]  end_word_i,
    input  logic [15:0] period_i,
    output logic [7:0]  sample_o,
    output logic        sample_stb_o,
    output logic        underrun_o,
    output logic        bus_err_o,
    input  logic        clr_flags_i,
    output logic        rambus_wb_clk_o,
    output logic        rambus_wb_rst_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [9:0]  rambus_wb_adr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t        state;
    logic              cyc;
    logic [9:0]        adr;
    logic [7:0]        word_idx;
    logic [7:0]        req_idx;
    logic [7:0]        end_eff;
    logic [7:0]        next_idx;
    logic [15:0]       wd;
    logic              en_d;
    logic              rise;
    logic              restart;
    logic              discard;
    logic              timeout_hit;
    logic              slot_free;
    logic [15:0]       tick_cnt;
    logic [15:0]       reload;
    logic              tick;
    logic [1:0]        byte_idx;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] head;

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_n_i;
    assign rambus_wb_stb_o = cyc;
    assign rambus_wb_cyc_o = cyc;
    assign rambus_wb_we_o  = 1'b0;
    assign rambus_wb_sel_o = 4'hF;
    assign rambus_wb_dat_o = 32'd0;
    assign rambus_wb_adr_o = adr;

    always_comb begin
        rise        = enable_i && !en_d;
        end_eff     = (end_word_i < start_word_i) ? start_word_i : end_word_i;
        req_idx     = (restart || rise) ? start_word_i : word_idx;
        next_idx    = (word_idx >= end_eff || word_idx < start_word_i)
                      ? start_word_i : word_idx + 8'd1;
        slot_free   = (fifo_count < CW'(FIFO_DEPTH));
        timeout_hit = (state == BUS_REQ) && !rambus_wb_ack_i && (wd == 16'(TIMEOUT - 1));
        // A cycle that saw enable low at any point belongs to the old sequence.
        push        = (state == BUS_REQ) && rambus_wb_ack_i && !discard && enable_i && !fifo_full;
        reload      = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
        tick        = enable_i && (tick_cnt == 16'd0);
        pop         = tick && !fifo_empty && (byte_idx == 2'd3);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= BUS_IDLE;
            cyc       <= 1'b0;
            adr       <= '0;
            word_idx  <= '0;
            wd        <= '0;
            en_d      <= 1'b0;
            restart   <= 1'b1;
            discard   <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            en_d      <= enable_i;
            bus_err_o <= timeout_hit || (bus_err_o && !clr_flags_i);
            case (state)
                BUS_IDLE: begin
                    wd      <= '0;
                    discard <= 1'b0;
                    if (enable_i && slot_free) begin
                        state    <= BUS_REQ;
                        cyc      <= 1'b1;
                        adr      <= {req_idx, 2'b00};
                        word_idx <= req_idx;
                        restart  <= 1'b0;
                    end else if (rise) begin
                        restart <= 1'b1;
                    end
                end
                BUS_REQ: begin
                    if (!enable_i) discard <= 1'b1;
                    if (rise)      restart <= 1'b1;
                    if (rambus_wb_ack_i) begin
                        state <= BUS_IDLE;
                        cyc   <= 1'b0;
                        if (push) word_idx <= next_idx;
                    end else if (timeout_hit) begin
                        state <= BUS_IDLE;
                        cyc   <= 1'b0;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                default: begin
                    state <= BUS_IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

    // Sample engine: ticks only while enabled; disable flushes pacing and byte position.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tick_cnt     <= '0;
            byte_idx     <= '0;
            sample_o     <= '0;
            sample_stb_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            sample_stb_o <= 1'b0;
            underrun_o   <= (tick && fifo_empty) || (underrun_o && !clr_flags_i);
            if (!enable_i) begin
                tick_cnt <= '0;
                byte_idx <= '0;
            end else begin
                tick_cnt <= (tick_cnt == 16'd0) ? reload : tick_cnt - 16'd1;
                if (tick && !fifo_empty) begin
                    sample_o     <= word_byte(head, byte_idx);
                    sample_stb_o <= 1'b1;
                    byte_idx     <= byte_idx + 2'd1;
                end
            end
        end
    end

    rambus_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .flush     (!enable_i),
        .push      (push),
        .push_data (rambus_wb_dat_i),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
